alu_logic_sched: RTL and testbench

Two-requester scheduler for the shared 4-bit logic unit (AND/OR/XOR/XNOR) of the ALU. It arbitrates round-robin between two clients and executes the granted operation bitwise on all four bits. It registers the result with the requester ID and a zero flag, and holds that result on a valid/ready output until it is consumed. It sits between the instruction-issue logic and the result write-back path.

---
 rtl/alu_logic_sched_if.sv | 78 +++++++
 rtl/alu_logic_sched.sv | 167 ++++++++++++++++
 tb/tb_alu_logic_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_logic_sched_if.sv
//------------------------------------------------------------------------------
// alu_logic_sched_if
//
// Purpose
//   Bundles the request and result handshakes of the two-requester logic-unit
//   scheduler. The issue side drives the requests and accepts results through
//   the master modport. The scheduler sits on the slave modport.
//
// Signal summary
//   req_valid[1:0]   issue -> sched   per-requester request valid (bit i = req i)
//   req_ready[1:0]   sched -> issue   per-requester accept, at most one bit high
//   req0_op/req1_op  issue -> sched   opcode 00 AND, 01 OR, 10 XOR, 11 XNOR
//   req0_a/req0_b    issue -> sched   requester 0 operands (4 bits)
//   req1_a/req1_b    issue -> sched   requester 1 operands (4 bits)
//   res_valid        sched -> wb      result valid
//   res_ready        wb -> sched      downstream accept
//   res_id           sched -> wb      requester that issued the result
//   res_data[3:0]    sched -> wb      result bits
//   res_zero         sched -> wb      high when res_data is all zeros
//   op_count[7:0]    sched -> wb      completed result handshakes, wraps at 256
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface alu_logic_sched_if;

   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [1:0] req0_op;
   logic [1:0] req1_op;
   logic [3:0] req0_a;
   logic [3:0] req0_b;
   logic [3:0] req1_a;
   logic [3:0] req1_b;

   logic       res_valid;
   logic       res_ready;
   logic       res_id;
   logic [3:0] res_data;
   logic       res_zero;
   logic [7:0] op_count;

   // Issue logic and write-back side: drives requests and result acceptance.
   modport master (
      output req_valid,
      output req0_op,
      output req1_op,
      output req0_a,
      output req0_b,
      output req1_a,
      output req1_b,
      output res_ready,
      input  req_ready,
      input  res_valid,
      input  res_id,
      input  res_data,
      input  res_zero,
      input  op_count
   );

   // Scheduler side: grants requests and presents registered results.
   modport slave (
      input  req_valid,
      input  req0_op,
      input  req1_op,
      input  req0_a,
      input  req0_b,
      input  req1_a,
      input  req1_b,
      input  res_ready,
      output req_ready,
      output res_valid,
      output res_id,
      output res_data,
      output res_zero,
      output op_count
   );

endinterface

// File: rtl/alu_logic_sched.sv
//------------------------------------------------------------------------------
// alu_logic_sched
//
// Purpose
//   Round-robin scheduler in front of the shared 4-bit logic unit of the ALU.
//   Two clients each present an opcode and a pair of 4-bit operands. One
//   client is granted at a time. Its operation (AND/OR/XOR/XNOR) is evaluated
//   bitwise and registered together with the client ID and a zero flag. The
//   result is held on a valid/ready output until write-back consumes it.
//
// Ports
//   clk   in   single clock, all state updates on the rising edge
//   rst   in   synchronous, active-high reset
//   bus   slave modport of alu_logic_sched_if (request and result handshakes)
//
// Behaviour summary
//   IDLE : req_ready reflects the round-robin grant. An accepted request moves
//          the block to RESP with the result, ID and zero flag registered.
//   RESP : res_valid is high and the result is frozen. No request is accepted.
//          The result handshake bumps op_count and returns the block to IDLE.
//   Throughput is one result every two cycles when res_ready is held high.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_logic_sched (
   input  logic             clk,
   input  logic             rst,
   alu_logic_sched_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_e;

   state_e     state_q;
   state_e     state_d;
   logic       last_grant_q;
   logic       last_grant_d;
   logic [3:0] res_data_q;
   logic [3:0] res_data_d;
   logic       res_id_q;
   logic       res_id_d;
   logic       res_zero_q;
   logic       res_zero_d;
   logic [7:0] op_count_q;
   logic [7:0] op_count_d;

   logic [1:0] grant;
   logic       sel_id;
   logic [1:0] sel_op;
   logic [3:0] sel_a;
   logic [3:0] sel_b;
   logic [3:0] sel_result;

   // Round-robin grant. A lone requester always wins. When both are valid the
   // one that did not win last time is granted, so each client waits at most
   // one result slot behind the other. Nothing is granted in RESP, and nothing
   // is granted while reset is asserted, which keeps an accept from appearing
   // to happen on an edge that reset actually wins.
   always_comb begin
      grant = 2'b00;
      if ((state_q == IDLE) && !rst) begin
         case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   assign bus.req_ready = grant;

   // Steer the granted requester's payload into the shared logic unit. When
   // nothing is granted the mux output is ignored, so requester 0 is the
   // default choice.
   always_comb begin
      sel_id = 1'b0;
      sel_op = bus.req0_op;
      sel_a  = bus.req0_a;
      sel_b  = bus.req0_b;
      if (grant[1]) begin
         sel_id = 1'b1;
         sel_op = bus.req1_op;
         sel_a  = bus.req1_a;
         sel_b  = bus.req1_b;
      end
   end

   // The shared logic unit itself. All four operations are bitwise, so every
   // result bit depends only on the matching pair of operand bits.
   always_comb begin
      sel_result = 4'b0000;
      case (sel_op)
         2'b00:   sel_result = sel_a & sel_b;
         2'b01:   sel_result = sel_a | sel_b;
         2'b10:   sel_result = sel_a ^ sel_b;
         default: sel_result = ~(sel_a ^ sel_b);
      endcase
   end

   // Next-state logic. Every register holds by default. In IDLE an accept
   // captures the payload-derived result and remembers the winner for the
   // fairness rule. In RESP the result stays frozen until the handshake, which
   // is the only event that advances op_count. The 8-bit add wraps from 255
   // to 0 naturally.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      res_data_d   = res_data_q;
      res_id_d     = res_id_q;
      res_zero_d   = res_zero_q;
      op_count_d   = op_count_q;

      case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               res_data_d   = sel_result;
               res_id_d     = sel_id;
               res_zero_d   = (sel_result == 4'b0000);
               last_grant_d = sel_id;
               state_d      = RESP;
            end
         end
         RESP: begin
            if (bus.res_ready) begin
               op_count_d = op_count_q + 8'd1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Reset discards any held result and clears
   // the handshake count. last_grant resets to requester 1 so that requester 0
   // wins the first contended cycle after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         res_data_q   <= 4'b0000;
         res_id_q     <= 1'b0;
         res_zero_q   <= 1'b0;
         op_count_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         res_data_q   <= res_data_d;
         res_id_q     <= res_id_d;
         res_zero_q   <= res_zero_d;
         op_count_q   <= op_count_d;
      end
   end

   // res_valid comes straight from the state register, so every result-side
   // output is a flop and res_ready never reaches req_ready combinationally.
   assign bus.res_valid = (state_q == RESP);
   assign bus.res_data  = res_data_q;
   assign bus.res_id    = res_id_q;
   assign bus.res_zero  = res_zero_q;
   assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_logic_sched.sv
//------------------------------------------------------------------------------
// tb_alu_logic_sched
//
// Drives alu_logic_sched through its master-side interface. A reference model
// predicts every grant and pushes each expected result into a scoreboard
// queue. An independent monitor compares each presented result against the
// head of that queue and tracks the expected handshake count.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_logic_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;

   alu_logic_sched_if bus ();

   alu_logic_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       id;
      logic [3:0] data;
      logic       zero;
   } result_t;

   result_t    exp_q[$];
   int         compared   = 0;
   int         mismatched = 0;
   bit         started    = 1'b0;
   bit         m_busy     = 1'b0;
   int         m_last     = 1;
   logic [7:0] exp_count  = 8'd0;

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Global time limit so a stuck DUT can never hang the run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no end of test, expected completion before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: every check of the bench goes through here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference logic unit, evaluated bit by bit from the truth rule of each
   // opcode.
   function automatic logic [3:0] refLogic(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [3:0] r;
      r = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         case (op)
            2'd0:    r[i] = a[i] && b[i];
            2'd1:    r[i] = a[i] || b[i];
            2'd2:    r[i] = (a[i] != b[i]);
            default: r[i] = (a[i] == b[i]);
         endcase
      end
      return r;
   endfunction

   // Reference model. Runs just after each falling edge, once inputs are
   // settled. It predicts what the next rising edge does: which requester is
   // granted (or none), whether the block is busy holding a result, and which
   // result must later appear.
   always @(negedge clk) begin : model_blk
      int         win;
      logic [1:0] g;
      result_t    r;
      #2;
      if (started) begin
         checkOutput("res_valid", 32'(bus.res_valid), 32'(m_busy));
         if (rst) begin
            checkOutput("req_ready_rst", 32'(bus.req_ready), 32'd0);
            m_busy = 1'b0;
            m_last = 1;
            exp_q.delete();
         end else if (!m_busy) begin
            win = -1;
            if (bus.req_valid == 2'b11) win = 1 - m_last;
            else if (bus.req_valid[0]) win = 0;
            else if (bus.req_valid[1]) win = 1;
            g = 2'b00;
            if (win == 0) g = 2'b01;
            if (win == 1) g = 2'b10;
            checkOutput("req_ready_grant", 32'(bus.req_ready), 32'(g));
            if (win >= 0) begin
               r.id   = (win == 1);
               r.data = (win == 1) ? refLogic(bus.req1_op, bus.req1_a, bus.req1_b)
                                   : refLogic(bus.req0_op, bus.req0_a, bus.req0_b);
               r.zero = (r.data == 4'b0000);
               exp_q.push_back(r);
               m_last = win;
               m_busy = 1'b1;
            end
         end else begin
            checkOutput("req_ready_resp", 32'(bus.req_ready), 32'd0);
            if (bus.res_ready) m_busy = 1'b0;
         end
      end
   end

   // Monitor. Whenever a result is presented it must match the scoreboard
   // head, and it must stay matched for every cycle it is held. A completed
   // handshake retires the entry and advances the expected count.
   always @(negedge clk) begin : monitor_blk
      result_t e;
      if (started) begin
         checkOutput("op_count", 32'(bus.op_count), 32'(exp_count));
         if (bus.res_valid) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_result: got res_valid=1, expected 0 (no result pending) at %0t", $time);
            end else begin
               e = exp_q[0];
               checkOutput("res_id",   32'(bus.res_id),   32'(e.id));
               checkOutput("res_data", 32'(bus.res_data), 32'(e.data));
               checkOutput("res_zero", 32'(bus.res_zero), 32'(e.zero));
               if (bus.res_ready && !rst) begin
                  void'(exp_q.pop_front());
                  exp_count = exp_count + 8'd1;
               end
            end
         end
         if (rst) exp_count = 8'd0;
      end
   end

   // Drive all request-side inputs one time unit after the next rising edge.
   task automatic applyStimulus(input logic [1:0] v,
                                input logic [1:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                                input logic [1:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                                input logic rr);
      @(posedge clk);
      #1;
      bus.req_valid = v;
      bus.req0_op   = op0;
      bus.req0_a    = a0;
      bus.req0_b    = b0;
      bus.req1_op   = op1;
      bus.req1_a    = a1;
      bus.req1_b    = b1;
      bus.res_ready = rr;
   endtask

   // Hold the current inputs until requester id sees req_ready (bounded).
   task automatic waitReady(input int id);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.req_ready[id] === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      compared++;
      if (!seen) begin
         mismatched++;
         $display("[TB] FAIL wait_ready%0d: got no req_ready within 20 cycles, expected a grant", id);
      end
   endtask

   // Issue one request from a single requester and wait for its grant.
   task automatic sendReq(input int id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic rr);
      if (id == 0) applyStimulus(2'b01, op, a, b, 2'b00, 4'h0, 4'h0, rr);
      else         applyStimulus(2'b10, 2'b00, 4'h0, 4'h0, op, a, b, rr);
      waitReady(id);
   endtask

   task automatic idleCycle(input logic rr);
      applyStimulus(2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, rr);
   endtask

   initial begin : stim_blk
      logic [3:0] op_table [4];
      logic [1:0] o0, o1;
      logic [3:0] x0, y0, x1, y1;
      int         order[$];
      logic [1:0] wop [2];
      logic [3:0] wa [2];
      logic [3:0] wb [2];
      bit         pend [2];
      int         acc;
      int         np;

      op_table[0] = 4'b1000;
      op_table[1] = 4'b1110;
      op_table[2] = 4'b0110;
      op_table[3] = 4'b1001;

      bus.req_valid = 2'b00;
      bus.req0_op   = 2'b00;
      bus.req0_a    = 4'h0;
      bus.req0_b    = 4'h0;
      bus.req1_op   = 2'b00;
      bus.req1_a    = 4'h0;
      bus.req1_b    = 4'h0;
      bus.res_ready = 1'b0;

      // Reset held with random inputs.
      repeat (2) applyStimulus(2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                               2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      started = 1'b1;
      @(negedge clk);
      checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("rst_op_count",  32'(bus.op_count),  32'd0);
      checkOutput("rst_res_data",  32'(bus.res_data),  32'd0);
      idleCycle(1'b1);
      rst = 1'b0;

      // All four opcodes from requester 0.
      for (int k = 0; k < 4; k++) begin
         sendReq(0, 2'(k), 4'b1100, 4'b1010, 1'b1);
         idleCycle(1'b1);
         @(negedge clk);
         checkOutput("opc_valid", 32'(bus.res_valid), 32'd1);
         checkOutput("opc_data",  32'(bus.res_data),  32'(op_table[k]));
         checkOutput("opc_id",    32'(bus.res_id),    32'd0);
         checkOutput("opc_zero",  32'(bus.res_zero),  32'd0);
         idleCycle(1'b1);
         @(negedge clk);
         checkOutput("opc_valid_done", 32'(bus.res_valid), 32'd0);
      end
      checkOutput("opc_count", 32'(bus.op_count), 32'd4);

      // Zero flag from requester 1.
      sendReq(1, 2'b00, 4'b0101, 4'b1010, 1'b1);
      idleCycle(1'b1);
      @(negedge clk);
      checkOutput("zero_data", 32'(bus.res_data), 32'd0);
      checkOutput("zero_flag", 32'(bus.res_zero), 32'd1);
      checkOutput("zero_id",   32'(bus.res_id),   32'd1);
      idleCycle(1'b1);

      // Contention: both requesters continuously valid, new payload after
      // each grant.
      o0 = 2'($urandom); x0 = 4'($urandom); y0 = 4'($urandom);
      o1 = 2'($urandom); x1 = 4'($urandom); y1 = 4'($urandom);
      for (int n = 0; n < 40 && order.size() < 6; n++) begin
         applyStimulus(2'b11, o0, x0, y0, o1, x1, y1, 1'b1);
         @(negedge clk);
         if (bus.req_ready == 2'b01) begin
            order.push_back(0);
            o0 = 2'($urandom); x0 = 4'($urandom); y0 = 4'($urandom);
         end else if (bus.req_ready == 2'b10) begin
            order.push_back(1);
            o1 = 2'($urandom); x1 = 4'($urandom); y1 = 4'($urandom);
         end
      end
      checkOutput("cont_accepts", 32'(order.size()), 32'd6);
      foreach (order[k]) checkOutput("cont_order", 32'(order[k]), 32'(k % 2));
      idleCycle(1'b1);
      idleCycle(1'b1);

      // Backpressure: result frozen while req0 payload keeps changing.
      sendReq(0, 2'b10, 4'b0011, 4'b0101, 1'b0);
      for (int n = 0; n < 5; n++) begin
         applyStimulus(2'b01, 2'($urandom), 4'($urandom), 4'($urandom), 2'b00, 4'h0, 4'h0, 1'b0);
         @(negedge clk);
         checkOutput("bp_data",      32'(bus.res_data),  32'h6);
         checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
      end
      o0 = 2'($urandom); x0 = 4'($urandom); y0 = 4'($urandom);
      applyStimulus(2'b01, o0, x0, y0, 2'b00, 4'h0, 4'h0, 1'b1);
      @(negedge clk);
      checkOutput("bp_count_before", 32'(bus.op_count), 32'd11);
      applyStimulus(2'b01, o0, x0, y0, 2'b00, 4'h0, 4'h0, 1'b1);
      @(negedge clk);
      checkOutput("bp_reaccept",    32'(bus.req_ready), 32'd1);
      checkOutput("bp_count_after", 32'(bus.op_count),  32'd12);
      idleCycle(1'b1);
      idleCycle(1'b1);

      // Reset while a result is held, with a request and res_ready present.
      sendReq(1, 2'b01, 4'($urandom), 4'($urandom), 1'b0);
      idleCycle(1'b0);
      @(negedge clk);
      checkOutput("mid_valid_before", 32'(bus.res_valid), 32'd1);
      @(posedge clk);
      #1;
      rst           = 1'b1;
      bus.res_ready = 1'b1;
      bus.req_valid = 2'b11;
      @(posedge clk);
      #1;
      rst           = 1'b0;
      bus.req_valid = 2'b00;
      @(negedge clk);
      checkOutput("mid_valid_after", 32'(bus.res_valid), 32'd0);
      checkOutput("mid_count_after", 32'(bus.op_count),  32'd0);

      // Random traffic with random backpressure for exactly 256 handshakes.
      acc = 0;
      for (int i = 0; i < 2; i++) begin
         pend[i] = 1'b0;
         wop[i]  = 2'b00;
         wa[i]   = 4'h0;
         wb[i]   = 4'h0;
      end
      for (int n = 0; n < 5000 && acc < 256; n++) begin
         np = int'(pend[0]) + int'(pend[1]);
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && (acc + np < 256) && ($urandom_range(0, 3) != 0)) begin
               pend[i] = 1'b1;
               np++;
               wop[i] = 2'($urandom);
               wa[i]  = 4'($urandom);
               wb[i]  = 4'($urandom);
            end
         end
         applyStimulus({pend[1], pend[0]}, wop[0], wa[0], wb[0], wop[1], wa[1], wb[1],
                       ($urandom_range(0, 3) != 0));
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (pend[i] && (bus.req_ready[i] === 1'b1)) begin
               pend[i] = 1'b0;
               acc++;
            end
         end
      end
      checkOutput("wrap_accepts", 32'(acc), 32'd256);
      repeat (3) idleCycle(1'b1);
      @(negedge clk);
      checkOutput("wrap_count",     32'(bus.op_count),  32'd0);
      checkOutput("sb_drained",     32'(exp_q.size()),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
